// File: rtl/updown_cmd_sequencer.sv
// updown_cmd_sequencer: command front-end for a WIDTH-bit up/down counter.
// Takes LOAD/UP/DOWN/HOLD commands over a valid/ready handshake and expands
// them into per-cycle load/cin/en/ud drive. A one-entry pending buffer lets
// the next command queue behind the running one. When the next command is
// already pending as the current one finishes, it starts with no idle cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command present on cmd_op/cmd_arg
//   cmd_ready  sequencer accepts a command this cycle
//   cmd_op     00=LOAD 01=UP 10=DOWN 11=HOLD
//   cmd_arg    LOAD value, or cycle count N (0 means 2^WIDTH)
//   load       counter parallel-load strobe
//   cin        counter load value (0 outside LOAD)
//   en         counter enable
//   ud         counter direction, 1=up 0=down
//   busy       a command is executing or pending
//   done       one-cycle pulse after each command's last active cycle
module updown_cmd_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             load,
  output logic [WIDTH-1:0] cin,
  output logic             en,
  output logic             ud,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  logic [1:0]       state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_op_q, pend_op_d;
  logic [WIDTH-1:0] pend_arg_q, pend_arg_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH:0]   steps_q, steps_d;
  logic             ud_q, ud_d;
  logic             done_q, done_d;

  logic accept, active, last, start;

  assign cmd_ready = !rst && !pend_valid_q;
  assign accept    = cmd_valid && cmd_ready;
  assign active    = (state_q != ST_IDLE);
  // LOAD is always a single cycle; the others end when the step count hits 1.
  assign last      = (state_q == ST_LOAD) || (steps_q == (WIDTH+1)'(1));
  // Pop pending either from idle or at the end edge of the running command.
  assign start     = pend_valid_q && (!active || last);

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_arg_d   = pend_arg_q;
    arg_d        = arg_q;
    steps_d      = steps_q;
    ud_d         = ud_q;
    done_d       = 1'b0;

    if (active) begin
      if (last) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        steps_d = steps_q - (WIDTH+1)'(1);
      end
    end

    if (start) begin
      pend_valid_d = 1'b0;
      arg_d        = pend_arg_q;
      steps_d      = (pend_arg_q == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, pend_arg_q};
      unique case (pend_op_q)
        OP_LOAD: begin
          state_d = ST_LOAD;
          steps_d = (WIDTH+1)'(1);
        end
        OP_UP: begin
          state_d = ST_RUN;
          ud_d    = 1'b1;
        end
        OP_DOWN: begin
          state_d = ST_RUN;
          ud_d    = 1'b0;
        end
        default: state_d = ST_HOLD;
      endcase
    end

    // Cannot coincide with a pop: accept needs the pending slot empty.
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_op_d    = cmd_op;
      pend_arg_d   = cmd_arg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_op_q    <= 2'b00;
      pend_arg_q   <= '0;
      arg_q        <= '0;
      steps_q      <= '0;
      ud_q         <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_arg_q   <= pend_arg_d;
      arg_q        <= arg_d;
      steps_q      <= steps_d;
      ud_q         <= ud_d;
      done_q       <= done_d;
    end
  end

  assign load = (state_q == ST_LOAD);
  assign en   = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign cin  = (state_q == ST_LOAD) ? arg_q : '0;
  assign ud   = ud_q;
  assign done = done_q;
  assign busy = active || pend_valid_q;

endmodule

// File: tb/tb_updown_cmd_sequencer.sv
module tb_updown_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_arg = 4'd0;
  logic       load;
  logic [3:0] cin;
  logic       en;
  logic       ud;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_snap;
  logic [3:0] cn = 4'd0;

  updown_cmd_sequencer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .load      (load),
    .cin       (cin),
    .en        (en),
    .ud        (ud),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Behavioural model of the downstream 4-bit up/down counter.
  always @(posedge clk) begin
    if (load === 1'b1) cn <= cin;
    else if (en === 1'b1) cn <= (ud === 1'b1) ? cn + 4'd1 : cn - 4'd1;
  end

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_load", load, 0);
    chk("rst_en", en, 0);
    chk("rst_ud", ud, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cin", cin, 0);
    chk("rst_ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // LOAD 0100 from idle
    drive(2'b00, 4'b0100);
    tick();
    cmd_valid = 1'b0;
    chk("s1_ready_pend", cmd_ready, 0);
    chk("s1_busy_pend", busy, 1);
    chk("s1_en_pend", en, 0);
    tick();
    chk("s1_load", load, 1);
    chk("s1_en", en, 1);
    chk("s1_cin", cin, 4'b0100);
    chk("s1_done_early", done, 0);
    tick();
    chk("s1_done", done, 1);
    chk("s1_load_off", load, 0);
    chk("s1_cin_off", cin, 0);
    chk("s1_busy_off", busy, 0);
    chk("s1_cn", cn, 4'b0100);
    tick();
    chk("s1_done_once", done, 0);

    // LOAD 0100 then UP 3 issued as soon as ready rises
    done_snap = done_cnt;
    drive(2'b00, 4'b0100);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("s2_load", load, 1);
    chk("s2_ready_after_pop", cmd_ready, 1);
    drive(2'b01, 4'd3);
    tick();
    cmd_valid = 1'b0;
    chk("s2_load_done", done, 1);
    chk("s2_busy_pend", busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_up_en", en, 1);
      chk("s2_up_ud", ud, 1);
      chk("s2_up_load", load, 0);
    end
    tick();
    chk("s2_up_done", done, 1);
    chk("s2_en_off", en, 0);
    chk("s2_cn", cn, 4'b0111);
    tick();
    chk("s2_done_pulses", done_cnt - done_snap, 2);

    // LOAD 0010 then DOWN 0 (16 steps)
    drive(2'b00, 4'b0010);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("s3_load", load, 1);
    drive(2'b10, 4'd0);
    tick();
    cmd_valid = 1'b0;
    chk("s3_load_done", done, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("s3_dn_en", en, 1);
      chk("s3_dn_ud", ud, 0);
      chk("s3_busy", busy, 1);
    end
    tick();
    chk("s3_done", done, 1);
    chk("s3_en_off", en, 0);
    chk("s3_busy_off", busy, 0);
    chk("s3_cn", cn, 4'b0010);
    tick();

    // HOLD 5 then UP 1 chained without a bubble; ud is 0 from DOWN
    drive(2'b11, 4'd5);
    tick();
    drive(2'b01, 4'd1);
    chk("s4_ready_hold_pend", cmd_ready, 0);
    tick();
    chk("s4_hold_en", en, 0);
    chk("s4_hold_ud", ud, 0);
    chk("s4_ready_free", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s4_ready_up_pend", cmd_ready, 0);
      chk("s4_hold_en", en, 0);
      chk("s4_hold_ud", ud, 0);
      chk("s4_hold_done", done, 0);
      if (i < 3) tick();
    end
    tick();
    chk("s4_up_en", en, 1);
    chk("s4_up_ud", ud, 1);
    chk("s4_hold_done_pulse", done, 1);
    tick();
    chk("s4_up_done", done, 1);
    chk("s4_en_off", en, 0);
    chk("s4_busy_off", busy, 0);
    chk("s4_cn", cn, 4'b0011);
    tick();

    // Reset mid UP 8 with a DOWN pending, after 3 enable edges
    drive(2'b01, 4'd8);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("s5_en1", en, 1);
    drive(2'b10, 4'd2);
    tick();
    cmd_valid = 1'b0;
    chk("s5_en2", en, 1);
    tick();
    chk("s5_en3", en, 1);
    rst = 1'b1;
    tick();
    chk("s5_rst_en", en, 0);
    chk("s5_rst_load", load, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_done", done, 0);
    chk("s5_rst_ready", cmd_ready, 0);
    chk("s5_cn", cn, 4'b0110);
    rst = 1'b0;
    tick();
    chk("s5_ready", cmd_ready, 1);
    chk("s5_pend_dropped", busy, 0);
    tick();
    chk("s5_no_run", en, 0);
    chk("s5_no_done", done, 0);

    // cmd_valid pulsed while not ready is ignored
    done_snap = done_cnt;
    drive(2'b00, 4'd9);
    tick();
    drive(2'b01, 4'd5);
    chk("s6_ready_low", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    chk("s6_load", load, 1);
    chk("s6_cin", cin, 4'd9);
    tick();
    chk("s6_done", done, 1);
    tick();
    chk("s6_busy_off", busy, 0);
    chk("s6_en_off", en, 0);
    tick();
    chk("s6_en_still_off", en, 0);
    chk("s6_cn", cn, 4'd9);
    chk("s6_done_pulses", done_cnt - done_snap, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
